// File: rtl/delay_var_en_pkg.sv
// delay_var_en_pkg: shared CNN-common helpers for width derivation
package delay_var_en_pkg;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/delay_var_en_ctrl.sv
// delay_var_en_ctrl: pointer, fill count, programmed delay and config error tracking
module delay_var_en_ctrl import delay_var_en_pkg::*; #(
   parameter int MAX_DELAY     = 64,
   parameter int DEFAULT_DELAY = 8,
   parameter int DELAY_W       = clog2(MAX_DELAY + 1),
   parameter int AW            = (MAX_DELAY > 1) ? clog2(MAX_DELAY) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en_i,
   input  logic               cfg_load_i,
   input  logic [DELAY_W-1:0] delay_cfg_i,
   output logic [AW-1:0]      ptr_o,
   output logic               we_o,
   output logic               out_valid_o,
   output logic [DELAY_W-1:0] cur_delay_o,
   output logic               cfg_err_o
);

   localparam logic [DELAY_W-1:0] ONE   = DELAY_W'(1);
   localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);
   localparam logic [DELAY_W-1:0] DEF_D = DELAY_W'(DEFAULT_DELAY);

   logic [DELAY_W-1:0] ptr_q, ptr_d, fill_q, fill_d, delay_q, delay_d;
   logic               err_q, err_d, cfg_ok;

   // A load flushes the line and wins over En; otherwise advance and wrap at delay-1
   always_comb begin
      cfg_ok  = (delay_cfg_i != '0) && (delay_cfg_i <= MAX_D);
      we_o    = en_i && !cfg_load_i;
      ptr_d   = cfg_load_i ? '0 : !we_o ? ptr_q : (ptr_q == delay_q - ONE) ? '0 : ptr_q + ONE;
      fill_d  = cfg_load_i ? '0 : (we_o && fill_q != delay_q) ? fill_q + ONE : fill_q;
      delay_d = (cfg_load_i && cfg_ok) ? delay_cfg_i : delay_q;
      err_d   = err_q || (cfg_load_i && !cfg_ok);
   end

   // Control state; error flag is sticky until reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q   <= '0;
         fill_q  <= '0;
         delay_q <= DEF_D;
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         fill_q  <= fill_d;
         delay_q <= delay_d;
         err_q   <= err_d;
      end
   end

   assign ptr_o       = ptr_q[AW-1:0];
   assign out_valid_o = (fill_q == delay_q);
   assign cur_delay_o = delay_q;
   assign cfg_err_o   = err_q;

endmodule

// File: rtl/delay_var_en.sv
// delay_var_en: runtime-programmable, En-gated delay line on a circular register buffer
module delay_var_en import delay_var_en_pkg::*; #(
   parameter int SIG_DATA_WIDTH = 1,
   parameter int MAX_DELAY      = 64,
   parameter int DEFAULT_DELAY  = 8,
   parameter int DELAY_W        = clog2(MAX_DELAY + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      En,
   input  logic [SIG_DATA_WIDTH-1:0] Data_In,
   input  logic                      Cfg_Load,
   input  logic [DELAY_W-1:0]        Delay_Cfg,
   output logic [SIG_DATA_WIDTH-1:0] Data_Out,
   output logic                      Out_Valid,
   output logic [DELAY_W-1:0]        Cur_Delay,
   output logic                      Cfg_Err
);

   localparam int AW = (MAX_DELAY > 1) ? clog2(MAX_DELAY) : 1;

   logic [SIG_DATA_WIDTH-1:0] mem_q [MAX_DELAY];
   logic [AW-1:0]             ptr;
   logic                      we;

   delay_var_en_ctrl #(
      .MAX_DELAY    (MAX_DELAY),
      .DEFAULT_DELAY(DEFAULT_DELAY),
      .DELAY_W      (DELAY_W),
      .AW           (AW)
   ) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .en_i       (En),
      .cfg_load_i (Cfg_Load),
      .delay_cfg_i(Delay_Cfg),
      .ptr_o      (ptr),
      .we_o       (we),
      .out_valid_o(Out_Valid),
      .cur_delay_o(Cur_Delay),
      .cfg_err_o  (Cfg_Err)
   );

   // Write the sample at the shared pointer; reset wipes every entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MAX_DELAY; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[ptr] <= Data_In;
      end
   end

   // The entry about to be overwritten is the oldest sample, i.e. the delayed output
   assign Data_Out = mem_q[ptr];

endmodule

// File: tb/tb_delay_var_en.sv
// tb_delay_var_en: directed vector table plus hand-written reset sequences
module tb_delay_var_en;

   localparam int W    = 8;
   localparam int MAXD = 64;
   localparam int DW   = 7;

   logic          clk = 1'b0, reset = 1'b0, En = 1'b0, Cfg_Load = 1'b0;
   logic [W-1:0]  Data_In = '0;
   logic [DW-1:0] Delay_Cfg = '0;
   logic [W-1:0]  Data_Out;
   logic          Out_Valid, Cfg_Err;
   logic [DW-1:0] Cur_Delay;

   always #5 clk = ~clk;

   delay_var_en #(.SIG_DATA_WIDTH(W), .MAX_DELAY(MAXD), .DEFAULT_DELAY(8)) dut (
      .clk(clk), .reset(reset), .En(En), .Data_In(Data_In), .Cfg_Load(Cfg_Load),
      .Delay_Cfg(Delay_Cfg), .Data_Out(Data_Out), .Out_Valid(Out_Valid),
      .Cur_Delay(Cur_Delay), .Cfg_Err(Cfg_Err)
   );

   typedef struct {
      logic          en;
      logic          load;
      logic [DW-1:0] cfg;
      logic [W-1:0]  din;
      logic          cd;
      logic [W-1:0]  eo;
      logic          ev;
      logic [DW-1:0] ec;
      logic          ee;
      string         tag;
   } vec_t;

   vec_t         vq[$];
   logic [W-1:0] hist[$];
   int           d_exp = 8;
   logic         err_exp = 1'b0;
   bit           clean = 1'b1;
   int           n_vec = 0, n_bad = 0;

   // Expected state after the edge: output is the sample D-1 En-edges old once primed
   function automatic void push(logic en, logic load, logic [DW-1:0] cfg, logic [W-1:0] din, string tag);
      vec_t v;
      int   k  = hist.size();
      bit   ok = (k >= d_exp);
      v.en = en; v.load = load; v.cfg = cfg; v.din = din;
      v.ev = ok;
      v.cd = ok || clean;
      v.eo = ok ? hist[k - d_exp] : '0;
      v.ec = DW'(d_exp);
      v.ee = err_exp;
      v.tag = tag;
      vq.push_back(v);
   endfunction

   function automatic void adv(logic [W-1:0] d, string tag);
      hist.push_back(d);
      push(1'b1, 1'b0, '0, d, tag);
   endfunction

   function automatic void stall(string tag);
      push(1'b0, 1'b0, '0, 8'hEE, tag);
   endfunction

   function automatic void load(int cfg, logic en, logic [W-1:0] d, string tag);
      if (cfg >= 1 && cfg <= MAXD) d_exp = cfg;
      else err_exp = 1'b1;
      hist.delete();
      clean = 1'b0;
      push(en, 1'b1, DW'(cfg), d, tag);
   endfunction

   task automatic run();
      vec_t v;
      int   idx = 0;
      while (vq.size() > 0) begin
         v = vq.pop_front();
         En = v.en; Cfg_Load = v.load; Delay_Cfg = v.cfg; Data_In = v.din;
         @(posedge clk);
         #1;
         n_vec++;
         if ((v.cd && Data_Out !== v.eo) || Out_Valid !== v.ev || Cur_Delay !== v.ec || Cfg_Err !== v.ee) begin
            n_bad++;
            $display("FAIL %s #%0d: got out=%0h vld=%0b cur=%0d err=%0b, expected out=%0h(chk=%0b) vld=%0b cur=%0d err=%0b",
                     v.tag, idx, Data_Out, Out_Valid, Cur_Delay, Cfg_Err, v.eo, v.cd, v.ev, v.ec, v.ee);
         end
         idx++;
      end
      En = 1'b0; Cfg_Load = 1'b0;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", 32'(Data_Out), 0);
      check("rst_valid", 32'(Out_Valid), 0);
      check("rst_cur", 32'(Cur_Delay), 8);
      check("rst_err", 32'(Cfg_Err), 0);
      @(negedge clk) reset = 1'b1;
      for (int k = 1; k <= 20; k++) adv(W'(k), "t1_stream");
      run();
      load(8, 1'b0, '0, "t2_flush");
      for (int k = 1; k <= 20; k++) begin
         adv(W'(k), "t2_stream");
         if (k == 5) repeat (3) stall("t2_stall_unprimed");
         if (k == 12) repeat (2) stall("t2_stall_primed");
      end
      run();
      load(3, 1'b0, '0, "t3_load3");
      for (int k = 21; k <= 26; k++) adv(W'(k), "t3_stream");
      run();
      load(0, 1'b0, '0, "t4_cfg0");
      for (int k = 30; k <= 33; k++) adv(W'(k), "t4_after0");
      load(65, 1'b0, '0, "t4_cfg65");
      for (int k = 40; k <= 41; k++) adv(W'(k), "t4_after65");
      load(1, 1'b0, '0, "t4_cfg1");
      for (int k = 50; k <= 53; k++) adv(W'(k), "t4_d1");
      run();
      load(64, 1'b0, '0, "t5_cfg64");
      for (int k = 0; k < 200; k++) adv(W'(k * 7 + 3), "t5_d64");
      load(1, 1'b1, 8'hAA, "t5_load_with_en");
      adv(8'h55, "t5_after_load_en");
      adv(8'h66, "t5_after_load_en");
      load(5, 1'b0, '0, "t5_back_to_back");
      load(0, 1'b0, '0, "t5_back_to_back");
      load(2, 1'b0, '0, "t5_back_to_back");
      for (int k = 70; k <= 74; k++) adv(W'(k), "t5_d2");
      run();
      #3 reset = 1'b0;
      #1;
      check("async_data", 32'(Data_Out), 0);
      check("async_valid", 32'(Out_Valid), 0);
      check("async_cur", 32'(Cur_Delay), 8);
      check("async_err", 32'(Cfg_Err), 0);
      @(negedge clk) reset = 1'b1;
      hist.delete();
      d_exp = 8;
      err_exp = 1'b0;
      clean = 1'b1;
      for (int k = 1; k <= 10; k++) adv(W'(k + 100), "t6_reprime");
      run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
